nrz_bit_tx: RTL
===============

Name: nrz_bit_tx

Overview:
Serial NRZ bit transmitter driven from the 200 MHz base clock. It produces a `signal` line with an exactly programmable bit period (in base-clock cycles), serializing bytes from a valid/ready stream. It is the transmit end of the bit-clock-recovery path and serves as both the board test-stimulus source and the loopback partner.

Parameters:
DIV_W, 16, width of bit_period and of the internal period counter
DATA_W, 8, bits per accepted word
MIN_PERIOD, 4, smallest effective bit period; smaller bit_period values are clamped up to this

Ports:
clk_200M  input  1  base clock; all logic on its rising edge
rst  input  1  asynchronous, active-high reset
bit_period  input  DIV_W  clock cycles per transmitted bit
tx_data  input  DATA_W  word to serialize
tx_valid  input  1  tx_data valid
tx_ready  output  1  block accepts a word this cycle
msb_first  input  1  1 = MSB first, 0 = LSB first; latched with each word
prbs_mode  input  1  select internal PRBS7 source (only with PRBS7_EN)
signal  output  1  serial NRZ output, registered
bit_strobe  output  1  1-cycle pulse in every cycle where signal starts a new bit
busy  output  1  high while a word is being shifted
underrun  output  1  1-cycle pulse when the stream runs dry mid-transmission

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; signal=0, bit_strobe=0, busy=0, underrun=0.
  - tx_ready is forced 0 while rst is high.
  - Shift register and counters are cleared; LFSR is loaded with 7'h7F.
- Effective period: P = max(bit_period, MIN_PERIOD). It is latched together with msb_first on word acceptance, so changes mid-word have no effect.
- States:
  - IDLE: tx_ready=1, busy=0, signal holds its last level (NRZ idle, no forced level). On tx_valid&&tx_ready, load the shift register and go to SHIFT.
  - SHIFT: period counter runs 0..P-1 and bit index runs 0..DATA_W-1. A bit boundary occurs when the counter equals P-1.
- Timing, with acceptance at cycle t:
  - signal = bit0 and bit_strobe=1 at t+1.
  - bit k appears at t+1+k*P and is held exactly P cycles.
  - busy=1 from t+1.
- Back-to-back handshake:
  - In SHIFT, tx_ready=1 only during the final cycle of the last bit (counter=P-1, index=DATA_W-1).
  - If tx_valid is high then, the next word is accepted and its bit0 starts the following cycle. There is no gap and busy stays 1.
  - P and msb_first are re-latched for the new word.
- Underrun: in the final cycle of the last bit with tx_valid=0:
  - return to IDLE, busy=0 next cycle;
  - underrun pulses for 1 cycle, aligned with busy falling;
  - no underrun from IDLE itself.
- bit_strobe fires on every bit, including consecutive identical bit values.
- Counter widths: DIV_W bits, no wrap inside a bit; bit index is ceil(log2(DATA_W)) bits.
- tx_data and tx_valid are ignored except on the acceptance cycle.

Optional Feature:
Macro `PRBS7_EN`.
- Defined:
  - 7-bit Fibonacci LFSR, polynomial x^7+x^6+1. Output bit = lfsr[6]; feedback lfsr[6]^lfsr[5] shifted into bit 0; one step per transmitted bit.
  - prbs_mode is sampled only in IDLE or at a word boundary (final cycle of last bit). When 1, the block enters SHIFT with the LFSR as the source.
  - In PRBS mode: tx_ready=0, tx_data/tx_valid are ignored, and underrun never fires. P is re-latched every DATA_W bits.
  - Transmission continues until prbs_mode=0 at a word boundary, then the normal stream/IDLE rules apply.
- Not defined: prbs_mode is ignored, no LFSR exists, and behaviour is exactly the stream mode above.

Test Plan:
- Single word: bit_period=10, msb_first=1, tx_data=8'hA5 accepted at cycle 0.
  - signal = 1,0,1,0,0,1,0,1, each held 10 cycles, starting at cycle 1.
  - 8 bit_strobe pulses at cycles 1,11,...,71.
  - underrun pulse at cycle 81, busy=0 from cycle 81, signal stays 1.
- Back-to-back: tx_valid held high with 8'hFF then 8'h00, LSB-first, bit_period=4.
  - Second word is accepted in cycle 32; signal falls at cycle 33.
  - busy stays continuously 1; no underrun.
- Clamp: bit_period=1 then bit_period=0 → every bit lasts exactly 4 cycles (MIN_PERIOD).
- Mid-word period change: bit_period 10→20 at bit 3 of a word → that word keeps 10-cycle bits; the next accepted word uses 20.
- Async reset: assert rst at bit 5 of a word.
  - signal=0, busy=0, tx_ready=0 immediately, with no clock edge needed.
  - After release, tx_ready=1 and a new word transmits normally.
- PRBS7 (`PRBS7_EN` defined), prbs_mode=1 from reset, bit_period=8.
  - First 7 bits are 1 and the 8th bit is 0.
  - The bit sequence repeats every 127 bits.
  - tx_ready stays 0 throughout.

Source files
------------

// File: rtl/nrz_bit_tx.sv
// nrz_bit_tx: NRZ serializer with programmable bit period and valid/ready input.
// Optional PRBS7 source compiled in with `PRBS7_EN.
module nrz_bit_tx #(
  parameter int DIV_W      = 16,
  parameter int DATA_W     = 8,
  parameter int MIN_PERIOD = 4
) (
  input  logic              clk_200M,
  input  logic              rst,
  input  logic [DIV_W-1:0]  bit_period,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              msb_first,
  input  logic              prbs_mode,
  output logic              signal,
  output logic              bit_strobe,
  output logic              busy,
  output logic              underrun
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] PMIN = DIV_W'(MIN_PERIOD);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  per_q, per_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic              msb_q, msb_d;
  logic              signal_q, signal_d;
  logic              strobe_q, strobe_d;
  logic              busy_q, busy_d;
  logic              undr_q, undr_d;

  logic [DIV_W-1:0]  per_eff;
  logic              bit_end, word_end, at_bound;
  logic              prbs_go, prbs_word, rdy, accept;

`ifdef PRBS7_EN
  logic [6:0] lfsr_q, lfsr_d;
  logic       prbs_q, prbs_d;

  assign prbs_go   = at_bound && prbs_mode;
  assign prbs_word = prbs_q;
`else
  logic unused_prbs;

  assign unused_prbs = prbs_mode;
  assign prbs_go     = 1'b0;
  assign prbs_word   = 1'b0;
`endif

  assign per_eff  = (bit_period < PMIN) ? PMIN : bit_period;
  assign bit_end  = (state_q == SHIFT) &&
                    (cnt_q == per_q - DIV_W'(1));
  assign word_end = bit_end && (idx_q == LAST_IDX);
  assign at_bound = (state_q == IDLE) || word_end;
  assign rdy      = at_bound && !prbs_go;
  assign accept   = rdy && tx_valid;
  assign tx_ready = rdy && !rst;

  // Next-state: word load, bit advance, word end / underrun
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    idx_d    = idx_q;
    sr_d     = sr_q;
    msb_d    = msb_q;
    signal_d = signal_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;
    undr_d   = 1'b0;
`ifdef PRBS7_EN
    lfsr_d   = lfsr_q;
    prbs_d   = prbs_q;
`endif
    if (prbs_go) begin
      state_d  = SHIFT;
      cnt_d    = '0;
      idx_d    = '0;
      per_d    = per_eff;
      strobe_d = 1'b1;
      busy_d   = 1'b1;
`ifdef PRBS7_EN
      signal_d = lfsr_q[6];
      lfsr_d   = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
      prbs_d   = 1'b1;
`endif
    end else if (accept) begin
      state_d  = SHIFT;
      cnt_d    = '0;
      idx_d    = '0;
      per_d    = per_eff;
      msb_d    = msb_first;
      strobe_d = 1'b1;
      busy_d   = 1'b1;
      if (msb_first) begin
        signal_d = tx_data[DATA_W-1];
        sr_d     = tx_data << 1;
      end else begin
        signal_d = tx_data[0];
        sr_d     = tx_data >> 1;
      end
`ifdef PRBS7_EN
      prbs_d   = 1'b0;
`endif
    end else if (word_end) begin
      state_d  = IDLE;
      cnt_d    = '0;
      idx_d    = '0;
      busy_d   = 1'b0;
      undr_d   = !prbs_word;
`ifdef PRBS7_EN
      prbs_d   = 1'b0;
`endif
    end else if (bit_end) begin
      cnt_d    = '0;
      idx_d    = idx_q + IW'(1);
      strobe_d = 1'b1;
`ifdef PRBS7_EN
      if (prbs_q) begin
        signal_d = lfsr_q[6];
        lfsr_d   = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
      end else
`endif
      if (msb_q) begin
        signal_d = sr_q[DATA_W-1];
        sr_d     = sr_q << 1;
      end else begin
        signal_d = sr_q[0];
        sr_d     = sr_q >> 1;
      end
    end else if (state_q == SHIFT) begin
      cnt_d    = cnt_q + DIV_W'(1);
    end
  end

  // State and registered outputs, async clear
  always_ff @(posedge clk_200M or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      per_q    <= PMIN;
      idx_q    <= '0;
      sr_q     <= '0;
      msb_q    <= 1'b0;
      signal_q <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      undr_q   <= 1'b0;
`ifdef PRBS7_EN
      lfsr_q   <= 7'h7F;
      prbs_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      idx_q    <= idx_d;
      sr_q     <= sr_d;
      msb_q    <= msb_d;
      signal_q <= signal_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      undr_q   <= undr_d;
`ifdef PRBS7_EN
      lfsr_q   <= lfsr_d;
      prbs_q   <= prbs_d;
`endif
    end
  end

  assign signal     = signal_q;
  assign bit_strobe = strobe_q;
  assign busy       = busy_q;
  assign underrun   = undr_q;

endmodule
